mem_dp: RTL and testbench

- Simple dual-port synchronous RAM: one write port and one read port on the same clock.
- Successor to the single-port memory; adds:
  - per-lane byte enables;
  - selectable read-during-write behaviour;
  - optional output register;
  - read-valid strobe;
  - self-clearing of all contents after reset.
- Sits between datapath producers and consumers as scratch or queue storage.

---
 rtl/mem_dp.sv | 129 ++++++++++++
 tb/tb_mem_dp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dp.sv
// Simple dual-port RAM with lane byte-enables, selectable read-during-write and post-reset self-clear.
// Latency: read data 1 cycle after request (2 with OUT_REG=1); writes land at the request edge.
// Backpressure: none; busy is high during reset/clear and requests are dropped while it is set.
module mem_dp #(
  parameter int ADDR     = 4,
  parameter int WORD     = 8,
  parameter int LANES    = 2,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WORD-1:0]  wr_data,
  input  logic [LANES-1:0] wr_be,
  input  logic             rd_en,
  input  logic [ADDR-1:0]  rd_addr,
  output logic [WORD-1:0]  rd_data,
  output logic             rd_valid,
  output logic             busy
);

  localparam int DEPTH = 2 ** ADDR;
  localparam int LW    = WORD / LANES;
  // Counter value of the last entry to clear; counter is one bit wider than the address.
  localparam logic [ADDR:0] LAST = (ADDR + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nxt;
  logic [ADDR:0]   clr_cnt, clr_cnt_nxt;
  logic [WORD-1:0] mem [DEPTH];
  logic [WORD-1:0] rd_word;
  logic            rd_go;
  logic            s1_valid;
  logic [WORD-1:0] s1_data;

  assign busy  = (state == CLEAR);
  assign rd_go = (state == READY) && rd_en;

  // Next state: walk the clear counter across every entry, then settle in READY until reset.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == LAST) begin
        state_nxt = READY;
      end
    end
  end

  // State register; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Array write port: clear sweep has priority, otherwise per-lane writes. Untouched while rst is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt[ADDR-1:0]] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_be[i]) begin
            mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
          end
        end
      end
    end
  end

  // Read word: old contents, or in write-first mode the enabled lanes bypassed from the write port.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && wr_en && (wr_addr == rd_addr)) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          rd_word[i*LW +: LW] = wr_data[i*LW +: LW];
        end
      end
    end
  end

  // First read stage: capture on a request, otherwise hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic            p_valid;
      logic [WORD-1:0] p_data;
      // Optional output stage: delays the strobe one cycle and holds data between results.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid <= 1'b0;
          p_data  <= '0;
        end else begin
          p_valid <= s1_valid;
          if (s1_valid) begin
            p_data <= s1_data;
          end
        end
      end
      assign rd_valid = p_valid;
      assign rd_data  = p_data;
    end else begin : g_noreg
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_mem_dp.sv
// Testbench for mem_dp: two instances (read-first/no out reg, write-first/out reg) on shared stimulus.
// Latency: each cycle compares busy/rd_valid/rd_data of both instances against a reference model.
// Backpressure: none; directed scenarios followed by a randomized phase with occasional resets.
module tb_mem_dp;

  localparam int DEPTH = 16;
  localparam int LW    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_be;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, busy0, busy1;

  always #5 clk = ~clk;

  mem_dp #(.ADDR(4), .WORD(8), .LANES(2), .RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
  );

  mem_dp #(.ADDR(4), .WORD(8), .LANES(2), .RDW_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: contents, remaining clear cycles, and expected outputs per instance.
  logic [7:0] mm [DEPTH];
  int         clr_left = DEPTH;
  logic       e0_v = 1'b0;  // instance 0: result visible one edge after request
  logic [7:0] e0_d = 8'h00;
  logic       r1_v = 1'b0;  // instance 1: write-first result of the previous edge's request
  logic [7:0] r1_d = 8'h00;
  logic       e1_v = 1'b0;  // instance 1: visible output, one edge later still
  logic [7:0] e1_d = 8'h00;

  task automatic model_edge();
    logic [7:0] nw;
    if (rst) begin
      clr_left = DEPTH;
      e0_v = 1'b0; e0_d = 8'h00;
      r1_v = 1'b0; r1_d = 8'h00;
      e1_v = 1'b0; e1_d = 8'h00;
    end else begin
      e1_v = r1_v;
      if (r1_v) e1_d = r1_d;
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) foreach (mm[k]) mm[k] = 8'h00;
        e0_v = 1'b0;
        r1_v = 1'b0;
      end else begin
        nw = mm[wr_addr];
        for (int i = 0; i < 2; i++) if (wr_be[i]) nw[i*LW +: LW] = wr_data[i*LW +: LW];
        e0_v = rd_en;
        r1_v = rd_en;
        if (rd_en) begin
          e0_d = mm[rd_addr];
          r1_d = (wr_en && wr_addr == rd_addr) ? nw : mm[rd_addr];
        end
        if (wr_en) mm[wr_addr] = nw;
      end
    end
  endtask

  // One clock: update the model at the edge, compare both instances at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy0", busy0, clr_left > 0);
    check("busy1", busy1, clr_left > 0);
    check("valid0", rd_valid0, e0_v);
    check("data0", rd_data0, e0_d);
    check("valid1", rd_valid1, e1_v);
    check("data1", rd_data1, e1_d);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_en = 1'b0;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic read(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
    cycle();
    rd_en = 1'b0;
  endtask

  // Counts busy samples from the current falling edge until busy drops; bounded.
  task automatic busy_len(input string tag);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    check(tag, n, 16);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    foreach (mm[k]) mm[k] = 8'h00;

    // Reset and clear
    repeat (3) cycle();
    rst = 1'b0;
    busy_len("busy_len_reset");
    for (int a = 0; a < DEPTH; a++) begin
      read(4'(a));
      check("clear_rd", rd_data0, 8'h00);
    end
    idle(); cycle(); cycle();

    // Basic write/read and back-to-back reads
    write(4'd2, 8'h07, 2'b11);
    write(4'd3, 8'h05, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd2; cycle();
    check("rd2_l1", rd_data0, 8'h07);
    rd_addr = 4'd3; cycle();
    check("rd3_l1", rd_data0, 8'h05);
    check("rd2_l2", rd_data1, 8'h07);
    check("b2b_valid", rd_valid0 & rd_valid1, 1'b1);
    rd_en = 1'b0; cycle();
    check("rd3_l2", rd_data1, 8'h05);

    // Hold behaviour with rd_en low and rd_addr toggling
    for (int i = 0; i < 4; i++) begin
      rd_addr = 4'(i * 5);
      cycle();
      check("hold_data", rd_data0, 8'h05);
      check("hold_valid", rd_valid0, 1'b0);
    end

    // Byte enables
    write(4'd5, 8'hAB, 2'b11);
    write(4'd5, 8'hCD, 2'b01);
    read(4'd5);
    check("be_lo", rd_data0, 8'hAD);
    write(4'd5, 8'h12, 2'b10);
    read(4'd5);
    check("be_hi", rd_data0, 8'h1D);
    write(4'd5, 8'h77, 2'b00);
    read(4'd5);
    check("be_none", rd_data0, 8'h1D);
    cycle();

    // Read during write, same address
    write(4'd4, 8'h11, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h99; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd4;
    cycle();
    check("rdw_read_first", rd_data0, 8'h11);
    wr_en = 1'b0;
    cycle();
    check("rdw_after", rd_data0, 8'h99);
    check("rdw_write_first", rd_data1, 8'h99);
    rd_en = 1'b0;
    cycle();
    check("rdw_after_l2", rd_data1, 8'h99);

    // Randomized traffic with occasional resets; small address range forces collisions
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 5));
      rd_addr = 4'($urandom_range(0, 5));
      wr_data = 8'($urandom);
      wr_be   = 2'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0; idle();
    for (int n = 0; n < 40 && clr_left > 0; n++) cycle();
    check("rand_settle", clr_left, 0);

    // Reset mid-clear with requests during busy
    write(4'd0, 8'h5A, 2'b11);
    rst = 1'b1; cycle();
    rst = 1'b0;
    repeat (8) cycle();
    rst = 1'b1; cycle();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd0;
    busy_len("busy_len_midclear");
    idle();
    read(4'd0);
    check("midclear_rd0", rd_data0, 8'h00);
    check("midclear_valid", rd_valid0, 1'b1);
    cycle();
    check("midclear_rd0_l2", rd_data1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
